// File: rtl/nic_responder.sv
`default_nettype none
// ============================================================================
// Module      : nic_responder
// Description : NIC load/store responder. One single-entry input-channel
//               buffer (router -> CPU) and one single-entry output-channel
//               buffer (CPU -> router). The CPU reaches the NIC through
//               nicEn / nicEnWr / addr_nic. The router handshake is
//               send/ready, and output sends are gated by the VC polarity.
// Ports       :
//   clk          - system clock, all state updates on the rising edge
//   reset        - asynchronous active-high reset, clears all state
//   nicEn        - CPU accesses the NIC this cycle
//   nicEnWr      - 1 = CPU write, 0 = CPU read (qualified by nicEn)
//   addr_nic     - 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
//   d_in         - CPU write data
//   d_out        - CPU read data (combinational)
//   net_si       - router presents a packet on net_di
//   net_ri       - NIC can accept a packet from the router
//   net_di       - packet from the router
//   net_so       - NIC presents a packet on net_do
//   net_ro       - router can accept a packet
//   net_do       - packet to the router
//   net_polarity - router's current virtual-channel phase
// Revision    : 1.0 - initial release
// ============================================================================
module nic_responder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic [1:0]            addr_nic,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  localparam logic [1:0] c_addr_in_buf     = 2'b00;
  localparam logic [1:0] c_addr_in_status  = 2'b01;
  localparam logic [1:0] c_addr_out_buf    = 2'b10;
  localparam logic [1:0] c_addr_out_status = 2'b11;

  logic [DATA_WIDTH-1:0] r_in_buf;
  logic                  r_in_full;
  logic [DATA_WIDTH-1:0] r_out_buf;
  logic                  r_out_full;

  logic w_cpu_rd;
  logic w_cpu_wr;
  logic w_accept;
  logic w_pop;
  logic w_push_out;
  logic w_drain;

  assign w_cpu_rd = nicEn & ~nicEnWr;
  assign w_cpu_wr = nicEn & nicEnWr;

  // The router can only hand over a packet while the input buffer is empty.
  // While the buffer is full, net_ri is low, so a pop and an accept can never
  // land on the same edge. A new packet is taken at the earliest one cycle
  // after the pop.
  assign w_accept = net_si & ~r_in_full;

  // Reading the in-buf pops it only when it holds a packet. Reading it while
  // empty returns the stale contents and does not change any state.
  assign w_pop = w_cpu_rd & (addr_nic == c_addr_in_buf) & r_in_full;

  // The write is qualified with the full flag as sampled before the edge.
  // If a drain happens on the same edge, the write is still dropped.
  assign w_push_out = w_cpu_wr & (addr_nic == c_addr_out_buf) & ~r_out_full;

  // A packet goes out only when the router is ready and the packet's VC bit
  // matches the router's current phase.
  assign w_drain = r_out_full & net_ro & (r_out_buf[DATA_WIDTH-1] == net_polarity);

  assign net_ri = ~r_in_full;
  assign net_so = w_drain;
  assign net_do = r_out_buf;

  // Input channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in_buf  <= net_di;
        r_in_full <= 1'b1;
      end else if (w_pop) begin
        r_in_full <= 1'b0;
      end
    end
  end

  // Output channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else begin
      if (w_push_out) begin
        r_out_buf  <= d_in;
        r_out_full <= 1'b1;
      end else if (w_drain) begin
        r_out_full <= 1'b0;
      end
    end
  end

  // CPU read mux. Writes and idle cycles return zero.
  always_comb begin
    d_out = '0;
    if (w_cpu_rd) begin
      case (addr_nic)
        c_addr_in_buf:     d_out = r_in_buf;
        c_addr_in_status:  d_out = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
        c_addr_out_buf:    d_out = '0;
        c_addr_out_status: d_out = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
        default:           d_out = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nic_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nic_responder
// Description : Directed self-checking bench for nic_responder. Inputs
//               change on the falling edge and outputs are sampled shortly
//               after it, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nic_responder;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          nicEn;
  logic          nicEnWr;
  logic [1:0]    addr_nic;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          net_si;
  logic          net_ri;
  logic [DW-1:0] net_di;
  logic          net_so;
  logic          net_ro;
  logic [DW-1:0] net_do;
  logic          net_polarity;

  int errors = 0;
  int checks = 0;

  localparam logic [DW-1:0] c_pkt_a  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] c_pkt_b  = 64'h0000_0000_0000_DEAD;
  localparam logic [DW-1:0] c_pkt_c  = 64'h0000_0000_0000_0077;
  localparam logic [DW-1:0] c_out_a  = 64'h8000_0000_0000_0042;
  localparam logic [DW-1:0] c_out_b  = 64'h0000_0000_0000_0011;
  localparam logic [DW-1:0] c_out_x  = 64'h0000_0000_0000_0055;
  localparam logic [DW-1:0] c_one    = 64'h1;
  localparam logic [DW-1:0] c_zero   = 64'h0;

  always #5 clk = ~clk;

  nic_responder #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .addr_nic     (addr_nic),
    .d_in         (d_in),
    .d_out        (d_out),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  // Stimulus helpers: these only drive inputs and never compare anything.
  task automatic idle();
    nicEn = 1'b0; nicEnWr = 1'b0; addr_nic = 2'b00; d_in = '0;
  endtask

  task automatic set_read(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr_nic = a; #1;
  endtask

  task automatic set_write(input logic [1:0] a, input logic [DW-1:0] v);
    nicEn = 1'b1; nicEnWr = 1'b1; addr_nic = a; d_in = v;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    repeat (2) next();
    reset = 1'b0;
    next(); #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_net_ri got=%b exp=1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
    checks++; if (net_do !== c_zero) begin errors++; $display("FAIL reset_net_do got=%h exp=0", net_do); end
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL reset_d_out_idle got=%h exp=0", d_out); end
    set_read(2'b01);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL reset_in_status got=%h exp=0", d_out); end
    set_read(2'b11);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL reset_out_status got=%h exp=0", d_out); end
    idle();
  endtask

  task automatic test_input_channel();
    net_si = 1'b1; net_di = c_pkt_a;
    next(); net_si = 1'b0; net_di = '0; #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL in_ri_after_accept got=%b exp=0", net_ri); end
    set_read(2'b01);
    checks++; if (d_out !== c_one) begin errors++; $display("FAIL in_status_full got=%h exp=1", d_out); end
    set_read(2'b10);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL out_buf_read_zero got=%h exp=0", d_out); end
    set_read(2'b00);
    checks++; if (d_out !== c_pkt_a) begin errors++; $display("FAIL in_buf_read got=%h exp=%h", d_out, c_pkt_a); end
    next(); idle(); #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_ri_after_pop got=%b exp=1", net_ri); end
    set_read(2'b01);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL in_status_after_pop got=%h exp=0", d_out); end
    // A read of the empty in-buf gives the stale packet and changes nothing.
    set_read(2'b00);
    checks++; if (d_out !== c_pkt_a) begin errors++; $display("FAIL in_buf_stale got=%h exp=%h", d_out, c_pkt_a); end
    next(); idle(); #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_ri_after_empty_read got=%b exp=1", net_ri); end
  endtask

  task automatic test_in_full_ignore();
    net_si = 1'b1; net_di = c_pkt_a;
    next(); net_di = c_pkt_b;
    repeat (2) next();
    #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL in_full_ri got=%b exp=0", net_ri); end
    set_read(2'b00);
    checks++; if (d_out !== c_pkt_a) begin errors++; $display("FAIL in_full_keeps got=%h exp=%h", d_out, c_pkt_a); end
    // Pop while the router keeps presenting a packet. The pop edge must not
    // accept the packet, and the following edge must accept it.
    net_di = c_pkt_c;
    next(); idle(); #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL pop_no_accept_same_edge got=%b exp=1", net_ri); end
    next(); net_si = 1'b0; #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL accept_after_pop got=%b exp=0", net_ri); end
    set_read(2'b00);
    checks++; if (d_out !== c_pkt_c) begin errors++; $display("FAIL accept_after_pop_data got=%h exp=%h", d_out, c_pkt_c); end
    next(); idle();
  endtask

  task automatic test_output_channel();
    net_ro = 1'b1; net_polarity = 1'b0;
    set_write(2'b10, c_out_a);
    next(); idle(); #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL out_vc_block got=%b exp=0", net_so); end
    checks++; if (net_do !== c_out_a) begin errors++; $display("FAIL out_do got=%h exp=%h", net_do, c_out_a); end
    set_read(2'b11);
    checks++; if (d_out !== c_one) begin errors++; $display("FAIL out_status_full got=%h exp=1", d_out); end
    idle(); net_polarity = 1'b1; #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL out_so_polarity got=%b exp=1", net_so); end
    next(); #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL out_so_one_cycle got=%b exp=0", net_so); end
    set_read(2'b11);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL out_status_drained got=%h exp=0", d_out); end
    idle(); net_polarity = 1'b0;
  endtask

  task automatic test_write_drop();
    net_ro = 1'b0;
    set_write(2'b10, c_out_b);
    next(); set_write(2'b10, c_out_x);
    next(); idle(); #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL drop_so_not_ready got=%b exp=0", net_so); end
    checks++; if (net_do !== c_out_b) begin errors++; $display("FAIL drop_keeps_original got=%h exp=%h", net_do, c_out_b); end
    net_ro = 1'b1; #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL drop_drain_so got=%b exp=1", net_so); end
    checks++; if (net_do !== c_out_b) begin errors++; $display("FAIL drop_drain_do got=%h exp=%h", net_do, c_out_b); end
    next(); net_ro = 1'b0;
    // Load again, then write while the drain happens on the same edge.
    set_write(2'b10, c_out_b);
    next(); net_ro = 1'b1; set_write(2'b10, c_out_x);
    next(); idle(); net_ro = 1'b0; #1;
    set_read(2'b11);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL write_during_drain_status got=%h exp=0", d_out); end
    // Writes to the other addresses have no effect.
    set_write(2'b00, c_out_x);
    next(); set_write(2'b11, c_out_x);
    next(); idle(); #1;
    set_read(2'b01);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL write_other_in_status got=%h exp=0", d_out); end
    set_read(2'b11);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL write_other_out_status got=%h exp=0", d_out); end
    idle();
  endtask

  task automatic test_async_reset();
    net_ro = 1'b0; net_polarity = 1'b0;
    net_si = 1'b1; net_di = c_pkt_a; set_write(2'b10, c_out_b);
    next(); net_si = 1'b0; idle(); #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL areset_pre_ri got=%b exp=0", net_ri); end
    set_read(2'b11);
    checks++; if (d_out !== c_one) begin errors++; $display("FAIL areset_pre_out_full got=%h exp=1", d_out); end
    idle(); #1;
    // Reset is asserted mid-cycle, away from any clock edge.
    reset = 1'b1; #1;
    net_ro = 1'b1; #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL areset_ri got=%b exp=1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL areset_so got=%b exp=0", net_so); end
    checks++; if (net_do !== c_zero) begin errors++; $display("FAIL areset_do got=%h exp=0", net_do); end
    next(); reset = 1'b0; net_ro = 1'b0;
    next(); #1;
    set_read(2'b01);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL areset_in_status got=%h exp=0", d_out); end
    set_read(2'b11);
    checks++; if (d_out !== c_zero) begin errors++; $display("FAIL areset_out_status got=%h exp=0", d_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_input_channel();
    test_in_full_ignore();
    test_output_channel();
    test_write_drop();
    test_async_reset();
    repeat (2) next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
